uart_link_ctrl: RTL and testbench
=================================

Name: uart_link_ctrl

Overview:
- Sequences the shared UART transmitter between two byte sources.
  - Echo path: bytes completed by the UART receiver, buffered in a small FIFO.
  - Host path: a local byte-request port.
- Sits between the receiver (RX_DATA/RX_STATUS), the transmitter (TX_DATA/TX_EN/TX_STATUS) and host logic.
- Round-robin arbitration; one byte in flight at a time; runs in the 16x baud clock domain.

Parameters:
- FIFO_DEPTH, 4, echo FIFO entries; power of 2, range 2..16.
- ECHO_EN, 1, 1 = received bytes are queued for echo; 0 = receive path ignored.
- TX_START_TIMEOUT, 31, max cycles in WAIT_BUSY for the transmitter to go busy.

Ports:
- baud_clk  in  1  16x-oversampled baud clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- RX_DATA  in  8  last received byte; valid while RX_STATUS=1.
- RX_STATUS  in  1  receiver frame-done level; a rising edge marks a new byte.
- host_req  in  1  host has a byte to send; held until host_gnt.
- host_data  in  8  host byte; held stable while host_req=1.
- host_gnt  out  1  one-cycle pulse: host byte accepted (sampled this cycle).
- TX_DATA  out  8  byte to transmit; held stable from ISSUE until the next grant.
- TX_EN  out  1  one-cycle transmit start pulse.
- TX_STATUS  in  1  1 = transmitter idle, 0 = busy.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  echo FIFO occupancy.
- rx_overflow  out  1  sticky: a received byte was dropped because the FIFO was full.
- tx_timeout  out  1  sticky: the transmitter never went busy after TX_EN.

Behaviour:
- Reset values: host_gnt=0, TX_EN=0, TX_DATA=0, fifo_count=0, rx_overflow=0, tx_timeout=0.
  - FIFO pointers 0; state IDLE; last_grant=HOST, so echo wins the first tie.
  - rx_status_d=1, so a RX_STATUS level held high through reset is not captured.
  - A reset asserted mid-transfer aborts the FSM and flushes the FIFO.
- Capture:
  - rx_edge = RX_STATUS & ~rx_status_d & ECHO_EN.
  - On rx_edge, RX_DATA is written at that clock edge; fifo_count increments on the same edge.
- Overflow:
  - rx_edge with FIFO full and no pop in the same cycle: byte dropped, rx_overflow<=1.
  - Simultaneous push and pop while full: both succeed, count unchanged, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags rx_overflow and tx_timeout clear only on reset.
- FSM state IDLE:
  - Acts only if TX_STATUS=1 and (fifo non-empty or host_req=1).
  - Source select: if only one source is pending, it wins. If both are pending, the source other than last_grant wins.
  - On grant: TX_DATA<=head or host_data, last_grant updated, and the state goes to ISSUE.
  - Echo grant pops the FIFO on the same edge.
  - Host grant: host_gnt=1 for exactly this cycle (combinational from IDLE-and-host-selected).
- FSM state ISSUE: TX_EN=1 for one cycle (Moore); timer cleared; next state WAIT_BUSY.
- FSM state WAIT_BUSY:
  - TX_STATUS=0 -> WAIT_DONE.
  - Otherwise the timer increments; when timer==TX_START_TIMEOUT, tx_timeout<=1 and the state goes to IDLE.
- FSM state WAIT_DONE: TX_STATUS=1 -> IDLE; no limit on wait.
- Latency: if RX_STATUS first samples 1 at edge k with IDLE, transmitter idle and no host_req:
  - grant at edge k+1;
  - TX_EN high in the cycle after edge k+1.
- Throughput: at most one byte per transmitter frame. A byte is never sent twice; the FIFO pops exactly once per echo grant.
- host_req dropped before host_gnt is legal; no grant results.

Test Plan:
- Single echo: reset, TX_STATUS=1, RX_DATA=0xA5 with RX_STATUS rising -> fifo_count 0->1->0, TX_DATA=0xA5, TX_EN one-cycle pulse 2 edges after capture, host_gnt stays 0.
- Tie round-robin: FIFO holds 0x11, host_req=1 host_data=0x22, transmitter model busy 160 cycles per byte -> TX order 0x11, 0x22; then with 0x33 queued and host 0x44, order 0x33, 0x44; host_gnt pulses exactly twice.
- Overflow: transmitter held busy (TX_STATUS=0), 5 RX edges with 0x01..0x05, FIFO_DEPTH=4 -> fifo_count=4, rx_overflow=1; release TX_STATUS -> bytes 0x01..0x04 sent, 0x05 never sent.
- Push/pop collision: FIFO full, RX edge on the same cycle as an echo grant -> fifo_count stays 4, rx_overflow stays 0, new byte sent last.
- Timeout: TX_STATUS stuck at 1 after TX_EN -> tx_timeout=1 exactly 31 cycles after WAIT_BUSY entry, FSM back in IDLE, next byte still issued.
- Reset mid-operation: assert reset in WAIT_DONE with 3 bytes queued and RX_STATUS=1 -> next cycle all outputs at reset values; releasing reset with RX_STATUS still 1 captures nothing.

Source files
------------

// File: rtl/uart_link_ctrl.sv
// Shares one UART transmitter between received bytes queued for echo and a host byte port.
// Round-robin between the two sources, one byte in flight, all on the 16x baud clock.
module uart_link_ctrl #(
  parameter int FIFO_DEPTH       = 4,
  parameter bit ECHO_EN          = 1'b1,
  parameter int TX_START_TIMEOUT = 31
) (
  input  logic                        baud_clk,
  input  logic                        reset,
  input  logic [7:0]                  RX_DATA,
  input  logic                        RX_STATUS,
  input  logic                        host_req,
  input  logic [7:0]                  host_data,
  output logic                        host_gnt,
  output logic [7:0]                  TX_DATA,
  output logic                        TX_EN,
  input  logic                        TX_STATUS,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        rx_overflow,
  output logic                        tx_timeout,
  output logic [1:0]                  fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TX_START_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C  = TW'(TX_START_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          rx_status_d;
  logic          last_grant_host;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;

  logic rx_edge;
  logic fifo_full;
  logic echo_pend;
  logic can_grant;
  logic sel_echo;
  logic sel_host;
  logic push;
  logic pop;

  // Handshakes: RX_STATUS rising edge = one new byte; host_req/host_data held until the
  // host_gnt cycle, which is the cycle host_data is sampled; TX_EN is a single-cycle start
  // strobe and TX_STATUS low acknowledges that the transmitter has taken the byte.
  assign rx_edge   = RX_STATUS & ~rx_status_d & ECHO_EN;
  assign fifo_full = (count == FULL_COUNT);
  assign echo_pend = (count != '0);
  assign can_grant = ~reset & (state == IDLE) & TX_STATUS;

  // On a tie the source that did not win last time takes the transmitter.
  assign sel_echo = can_grant & echo_pend & (~host_req | last_grant_host);
  assign sel_host = can_grant & host_req & (~echo_pend | ~last_grant_host);

  assign pop  = sel_echo;
  assign push = rx_edge & (~fifo_full | pop);

  assign host_gnt   = sel_host;
  assign fifo_count = count;
  assign fsm_state  = state;
  assign timer_next = timer + 1'b1;

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge baud_clk) begin
    if (push) mem[wr_ptr] <= RX_DATA;
  end

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      rx_status_d     <= 1'b1;
      last_grant_host <= 1'b1;
      timer           <= '0;
      TX_DATA         <= 8'h00;
      TX_EN           <= 1'b0;
      rx_overflow     <= 1'b0;
      tx_timeout      <= 1'b0;
    end else begin
      rx_status_d <= RX_STATUS;
      TX_EN       <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (rx_edge && fifo_full && !pop) rx_overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (sel_echo || sel_host) begin
            TX_DATA         <= sel_echo ? mem[rd_ptr] : host_data;
            last_grant_host <= sel_host;
            TX_EN           <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!TX_STATUS) begin
            state <= WAIT_DONE;
          end else if (timer_next == TIMEOUT_C) begin
            tx_timeout <= 1'b1;
            state      <= IDLE;
          end else begin
            timer <= timer_next;
          end
        end
        WAIT_DONE: begin
          if (TX_STATUS) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed bench for uart_link_ctrl: a transmitter model, a host driver and a TX byte
// scoreboard running alongside directed echo / arbitration / overflow / timeout / reset cases.
module tb_uart_link_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // clock / reset and DUT signals
  logic          baud_clk  = 1'b0;
  logic          reset     = 1'b1;
  logic [7:0]    RX_DATA   = 8'h00;
  logic          RX_STATUS = 1'b0;
  logic          host_req  = 1'b0;
  logic [7:0]    host_data = 8'h00;
  logic          host_gnt;
  logic [7:0]    TX_DATA;
  logic          TX_EN;
  logic          TX_STATUS = 1'b1;
  logic [CW-1:0] fifo_count;
  logic          rx_overflow;
  logic          tx_timeout;
  logic [1:0]    fsm_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] host_q[$];

  int tx_frame      = 160;
  bit tx_force_busy = 1'b0;
  bit tx_ignore     = 1'b0;
  int busy_left     = 0;
  int host_gnt_cnt  = 0;

  always #5 baud_clk = ~baud_clk;

  uart_link_ctrl #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ECHO_EN(1'b1),
    .TX_START_TIMEOUT(31)
  ) dut (
    .baud_clk(baud_clk),
    .reset(reset),
    .RX_DATA(RX_DATA),
    .RX_STATUS(RX_STATUS),
    .host_req(host_req),
    .host_data(host_data),
    .host_gnt(host_gnt),
    .TX_DATA(TX_DATA),
    .TX_EN(TX_EN),
    .TX_STATUS(TX_STATUS),
    .fifo_count(fifo_count),
    .rx_overflow(rx_overflow),
    .tx_timeout(tx_timeout),
    .fsm_state(fsm_state)
  );

  // transmitter model: goes busy for tx_frame cycles after each TX_EN
  initial begin
    forever begin
      @(negedge baud_clk);
      #1;
      if (reset) begin
        busy_left = 0;
        TX_STATUS = 1'b1;
      end else if (tx_force_busy) begin
        TX_STATUS = 1'b0;
      end else if (TX_EN && !tx_ignore) begin
        busy_left = tx_frame;
        TX_STATUS = 1'b0;
      end else if (busy_left > 0) begin
        busy_left = busy_left - 1;
        TX_STATUS = 1'b0;
      end else begin
        TX_STATUS = 1'b1;
      end
    end
  end

  // host driver: presents queued bytes, drops the request after the granting edge
  initial begin
    bit granted;
    forever begin
      @(posedge baud_clk);
      granted = (host_req && host_gnt && !reset);
      if (granted) host_gnt_cnt = host_gnt_cnt + 1;
      @(negedge baud_clk);
      if (granted || reset) begin
        host_req = 1'b0;
      end else if (!host_req && host_q.size() > 0) begin
        host_data = host_q.pop_front();
        host_req  = 1'b1;
      end
    end
  end

  // scoreboard monitor: every TX_EN pulse must carry the next expected byte
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge baud_clk);
      if (!reset && TX_EN === 1'b1) begin
        vectors = vectors + 1;
        if (exp_q.size() == 0) begin
          miscompares = miscompares + 1;
          $display("FAIL tx_unexpected: got byte %02h, expected no transmission", TX_DATA);
        end else begin
          e = exp_q.pop_front();
          if (TX_DATA !== e) begin
            miscompares = miscompares + 1;
            $display("FAIL tx_byte: got %02h, expected %02h", TX_DATA, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion within 50000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge baud_clk);
    reset         = 1'b1;
    RX_STATUS     = 1'b0;
    tx_force_busy = 1'b0;
    tx_ignore     = 1'b0;
    repeat (3) @(negedge baud_clk);
    reset = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge baud_clk);
    RX_DATA   = b;
    RX_STATUS = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge baud_clk);
    RX_STATUS = 1'b0;
    @(negedge baud_clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge baud_clk);
    while (!(exp_q.size() == 0 && host_q.size() == 0 && !host_req && fsm_state == ST_IDLE &&
             TX_STATUS && busy_left == 0) && n < 6000) begin
      @(negedge baud_clk);
      n++;
    end
    vectors = vectors + 1;
    if (n >= 6000) begin
      miscompares = miscompares + 1;
      $display("FAIL %s_drain: got %0d bytes still pending, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    int g0;
    int n;

    // reset values, sampled while reset is held
    repeat (2) @(negedge baud_clk);
    check("rst_host_gnt", host_gnt, 0);
    check("rst_tx_en", TX_EN, 0);
    check("rst_tx_data", TX_DATA, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", rx_overflow, 0);
    check("rst_timeout", tx_timeout, 0);
    @(negedge baud_clk);
    reset = 1'b0;

    // single echo with capture-to-TX_EN latency
    g0 = host_gnt_cnt;
    exp_q.push_back(8'hA5);
    @(negedge baud_clk);
    RX_DATA   = 8'hA5;
    RX_STATUS = 1'b1;
    @(negedge baud_clk);
    check("echo_count_after_capture", fifo_count, 1);
    check("echo_tx_en_early", TX_EN, 0);
    @(negedge baud_clk);
    check("echo_count_after_grant", fifo_count, 0);
    check("echo_tx_en", TX_EN, 1);
    check("echo_tx_data", TX_DATA, 8'hA5);
    RX_STATUS = 1'b0;
    wait_idle("echo");
    check("echo_no_host_gnt", host_gnt_cnt - g0, 0);

    // round-robin on ties: echo wins first after reset, then alternation
    do_reset();
    g0 = host_gnt_cnt;
    tx_force_busy = 1'b1;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_rx(8'h11);
    host_q.push_back(8'h22);
    repeat (3) @(negedge baud_clk);
    check("tie1_fifo_count", fifo_count, 1);
    check("tie1_no_gnt_while_busy", host_gnt, 0);
    tx_force_busy = 1'b0;
    wait_idle("tie1");
    tx_force_busy = 1'b1;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    send_rx(8'h33);
    host_q.push_back(8'h44);
    repeat (3) @(negedge baud_clk);
    tx_force_busy = 1'b0;
    wait_idle("tie2");
    check("tie_host_gnt_pulses", host_gnt_cnt - g0, 2);

    // overflow: fifth byte dropped while the transmitter is held busy
    do_reset();
    tx_force_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_rx(8'(i));
    end
    check("ovf_count_full", fifo_count, 4);
    check("ovf_not_yet", rx_overflow, 0);
    send_rx(8'h05);
    check("ovf_count_after_drop", fifo_count, 4);
    check("ovf_flag", rx_overflow, 1);
    tx_force_busy = 1'b0;
    wait_idle("ovf");
    check("ovf_sticky", rx_overflow, 1);
    check("ovf_count_drained", fifo_count, 0);

    // push on a full FIFO in the same cycle as an echo pop
    do_reset();
    tx_force_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h41 + 8'(i));
      send_rx(8'h41 + 8'(i));
    end
    check("coll_count_full", fifo_count, 4);
    exp_q.push_back(8'h45);
    @(negedge baud_clk);
    tx_force_busy = 1'b0;
    RX_DATA       = 8'h45;
    RX_STATUS     = 1'b1;
    @(negedge baud_clk);
    check("coll_count", fifo_count, 4);
    check("coll_no_overflow", rx_overflow, 0);
    check("coll_tx_en", TX_EN, 1);
    RX_STATUS = 1'b0;
    wait_idle("coll");
    check("coll_no_overflow_end", rx_overflow, 0);

    // transmitter never goes busy: timeout 31 cycles after WAIT_BUSY entry
    do_reset();
    tx_ignore = 1'b1;
    exp_q.push_back(8'h5A);
    @(negedge baud_clk);
    RX_DATA   = 8'h5A;
    RX_STATUS = 1'b1;
    n = 0;
    do begin
      @(negedge baud_clk);
      n++;
    end while (TX_EN !== 1'b1 && n < 10);
    check("to_tx_en_seen", TX_EN, 1);
    repeat (31) @(negedge baud_clk);
    check("to_not_early", tx_timeout, 0);
    @(negedge baud_clk);
    check("to_flag", tx_timeout, 1);
    check("to_state_idle", fsm_state, ST_IDLE);
    RX_STATUS = 1'b0;
    tx_ignore = 1'b0;
    exp_q.push_back(8'h6B);
    send_rx(8'h6B);
    wait_idle("to_next");
    check("to_sticky", tx_timeout, 1);

    // reset in WAIT_DONE with bytes queued and RX_STATUS high
    do_reset();
    exp_q.push_back(8'h70);
    send_rx(8'h70);
    send_rx(8'h71);
    send_rx(8'h72);
    send_rx(8'h73);
    check("mid_state_wait_done", fsm_state, ST_WAIT_DONE);
    check("mid_count", fifo_count, 3);
    @(negedge baud_clk);
    reset     = 1'b1;
    RX_DATA   = 8'h74;
    RX_STATUS = 1'b1;
    @(negedge baud_clk);
    check("mid_rst_host_gnt", host_gnt, 0);
    check("mid_rst_tx_en", TX_EN, 0);
    check("mid_rst_tx_data", TX_DATA, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_overflow", rx_overflow, 0);
    check("mid_rst_timeout", tx_timeout, 0);
    check("mid_rst_state", fsm_state, ST_IDLE);
    reset = 1'b0;
    repeat (6) @(negedge baud_clk);
    check("mid_no_capture", fifo_count, 0);
    check("mid_idle_after", fsm_state, ST_IDLE);
    RX_STATUS = 1'b0;
    repeat (4) @(negedge baud_clk);

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
